cci_mpf_prim_heap_ctrl_multi: RTL and testbench

- Allocation-only heap index manager that generalises the single-free heap control to N_FREE_PORTS independent release ports per cycle.
- Adds an occupancy output, a sticky error flag for double/illegal frees, and a drain/quiescent indication.
- Sits beside a cci_mpf_prim_ram_simple data store in MPF shims (read-response reorder, write-data staging) where several pipelines retire entries in the same cycle.
- Free state is held in a bit vector; the lowest-numbered free entry is prefetched into allocIdx.

---
 rtl/cci_mpf_prim_heap_pkg.sv | 24 ++
 rtl/cci_mpf_prim_ffs.sv | 28 ++
 rtl/cci_mpf_prim_heap_ctrl_multi.sv | 137 +++++++++++++
 tb/tb_cci_mpf_prim_heap_ctrl_multi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_prim_heap_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_prim_heap_pkg
// Brief   : Shared width helpers and diagnostic strings for MPF heap allocators
// Revision: 1.0  initial release
// ============================================================================
package cci_mpf_prim_heap_pkg;

  // Width of an index that addresses n entries (at least one bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n itself
  function automatic int cnt_w(input int n);
    return idx_w(n) + 1;
  endfunction

  localparam string MSG_ENQ_FULL = "heap_ctrl: enq while notFull=0";
  localparam string MSG_BAD_FREE = "heap_ctrl: double, duplicate or out-of-range free";
  localparam string MSG_OVERFLOW = "heap_ctrl: free count would exceed N_ENTRIES";

endpackage
`default_nettype wire

// File: rtl/cci_mpf_prim_ffs.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_prim_ffs
// Brief   : Combinational lowest-set-bit finder
// Revision: 1.0  initial release
// ============================================================================
module cci_mpf_prim_ffs
  import cci_mpf_prim_heap_pkg::*;
#(
  parameter int N_BITS = 8,
  localparam int IDX_W = idx_w(N_BITS)
)(
  input  logic [N_BITS-1:0] i_vec,
  output logic              o_found,
  output logic [IDX_W-1:0]  o_idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    o_found = |i_vec;
    o_idx   = '0;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cci_mpf_prim_heap_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module  : cci_mpf_prim_heap_ctrl_multi
// Brief   : Heap index allocator with several release ports per cycle,
//           occupancy count, sticky misuse flag and empty indication
// Revision: 1.0  initial release
// ============================================================================
module cci_mpf_prim_heap_ctrl_multi
  import cci_mpf_prim_heap_pkg::*;
#(
  parameter int  N_ENTRIES      = 64,
  parameter int  N_FREE_PORTS   = 2,
  parameter int  MIN_FREE_SLOTS = 1,
  parameter bit  REPORT_ERRORS  = 1'b0,
  localparam int IDX_W          = idx_w(N_ENTRIES),
  localparam int CNT_W          = cnt_w(N_ENTRIES)
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enq,
  output logic                          notFull,
  output logic [IDX_W-1:0]              allocIdx,
  input  logic [N_FREE_PORTS-1:0]       free,
  input  logic [N_FREE_PORTS*IDX_W-1:0] freeIdx,
  output logic [CNT_W-1:0]              numFree,
  output logic                          empty,
  output logic                          error
);

  logic [N_ENTRIES-1:0]          r_free_vec;
  logic [IDX_W-1:0]              r_alloc_idx;
  logic                          r_alloc_valid;
  logic [CNT_W-1:0]              r_num_free;
  logic                          r_error;
  logic [N_FREE_PORTS-1:0]       r_free_q;
  logic [N_FREE_PORTS*IDX_W-1:0] r_free_idx_q;

  logic                          w_ffs_found;
  logic [IDX_W-1:0]              w_ffs_idx;
  logic                          w_enq_ok;
  logic                          w_enq_bad;
  logic                          w_reload;
  logic [N_FREE_PORTS-1:0]       w_port_ok;
  logic [N_FREE_PORTS-1:0]       w_port_bad;
  logic [CNT_W-1:0]              w_pop;
  logic                          w_over;
  logic [CNT_W-1:0]              w_num_next;
  logic [N_ENTRIES-1:0]          w_vec_next;

  cci_mpf_prim_ffs #(.N_BITS(N_ENTRIES)) u_ffs (
    .i_vec   (r_free_vec),
    .o_found (w_ffs_found),
    .o_idx   (w_ffs_idx)
  );

  assign notFull   = r_alloc_valid && (r_num_free >= CNT_W'(MIN_FREE_SLOTS));
  assign w_enq_ok  = enq && notFull;
  assign w_enq_bad = enq && !notFull;
  // The prefetch register refills when consumed or while it holds nothing
  assign w_reload  = w_enq_ok || !r_alloc_valid;

  // Classify each staged release; colliding ports are all rejected
  always_comb begin
    w_port_ok  = '0;
    w_port_bad = '0;
    w_pop      = '0;
    for (int p = 0; p < N_FREE_PORTS; p++) begin
      if (r_free_q[p]) begin
        if (({1'b0, r_free_idx_q[p*IDX_W +: IDX_W]} >= CNT_W'(N_ENTRIES)) ||
            r_free_vec[r_free_idx_q[p*IDX_W +: IDX_W]] ||
            (r_alloc_valid && (r_free_idx_q[p*IDX_W +: IDX_W] == r_alloc_idx)))
          w_port_bad[p] = 1'b1;
        for (int q = 0; q < N_FREE_PORTS; q++) begin
          if ((q != p) && r_free_q[q] &&
              (r_free_idx_q[q*IDX_W +: IDX_W] == r_free_idx_q[p*IDX_W +: IDX_W]))
            w_port_bad[p] = 1'b1;
        end
        w_port_ok[p] = !w_port_bad[p];
      end
      w_pop = w_pop + CNT_W'(w_port_ok[p]);
    end
  end

  // Next free count and free vector; releases are dropped if they would overflow
  always_comb begin
    w_over     = ({1'b0, r_num_free} + {1'b0, w_pop}) > (CNT_W+1)'(N_ENTRIES);
    w_num_next = r_num_free + (w_over ? '0 : w_pop) - CNT_W'(w_enq_ok);
    w_vec_next = r_free_vec;
    if (w_reload && w_ffs_found) w_vec_next[w_ffs_idx] = 1'b0;
    if (!w_over) begin
      for (int p = 0; p < N_FREE_PORTS; p++) begin
        if (w_port_ok[p]) w_vec_next[r_free_idx_q[p*IDX_W +: IDX_W]] = 1'b1;
      end
    end
  end

  // Allocator state, release staging and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_free_vec    <= {{(N_ENTRIES-1){1'b1}}, 1'b0};
      r_alloc_idx   <= '0;
      r_alloc_valid <= 1'b1;
      r_num_free    <= CNT_W'(N_ENTRIES);
      r_error       <= 1'b0;
      r_free_q      <= '0;
      r_free_idx_q  <= '0;
    end else begin
      r_free_vec   <= w_vec_next;
      r_num_free   <= w_num_next;
      r_free_q     <= free;
      r_free_idx_q <= freeIdx;
      if (w_enq_bad || (|w_port_bad) || w_over) r_error <= 1'b1;
      if (w_reload) begin
        r_alloc_valid <= w_ffs_found;
        if (w_ffs_found) r_alloc_idx <= w_ffs_idx;
      end
    end
  end

  assign allocIdx = r_alloc_idx;
  assign numFree  = r_num_free;
  assign empty    = (r_num_free == CNT_W'(N_ENTRIES));
  assign error    = r_error;

  if (REPORT_ERRORS) begin : g_report
    // Simulation-time diagnostics for each misuse class
    always_ff @(posedge clk) begin
      if (reset) begin
        if (w_enq_bad)   $error("%s", MSG_ENQ_FULL);
        if (|w_port_bad) $error("%s", MSG_BAD_FREE);
        if (w_over)      $error("%s", MSG_OVERFLOW);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_prim_heap_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_cci_mpf_prim_heap_ctrl_multi
// Brief   : Directed self-checking bench for the multi-port heap allocator
// Revision: 1.0  initial release
// ============================================================================
module tb_cci_mpf_prim_heap_ctrl_multi;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 64-entry instance, MIN_FREE_SLOTS=1
  logic        rst64 = 1'b0;
  logic        enq64 = 1'b0;
  logic [1:0]  free64 = '0;
  logic [11:0] fidx64 = '0;
  logic        nf64, emp64, err64;
  logic [5:0]  aidx64;
  logic [6:0]  num64;

  // 48-entry instance, MIN_FREE_SLOTS=4
  logic        rst48 = 1'b0;
  logic        enq48 = 1'b0;
  logic [1:0]  free48 = '0;
  logic [11:0] fidx48 = '0;
  logic        nf48, emp48, err48;
  logic [5:0]  aidx48;
  logic [6:0]  num48;

  int n_checks = 0;
  int n_errors = 0;

  cci_mpf_prim_heap_ctrl_multi #(.N_ENTRIES(64), .N_FREE_PORTS(2), .MIN_FREE_SLOTS(1)) u_dut64 (
    .clk(clk), .reset(rst64), .enq(enq64), .notFull(nf64), .allocIdx(aidx64),
    .free(free64), .freeIdx(fidx64), .numFree(num64), .empty(emp64), .error(err64)
  );

  cci_mpf_prim_heap_ctrl_multi #(.N_ENTRIES(48), .N_FREE_PORTS(2), .MIN_FREE_SLOTS(4)) u_dut48 (
    .clk(clk), .reset(rst48), .enq(enq48), .notFull(nf48), .allocIdx(aidx48),
    .free(free48), .freeIdx(fidx48), .numFree(num48), .empty(emp48), .error(err48)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    rst64 = 1'b1;
    rst48 = 1'b1;
    tick();

    // Reset state
    check_val("rst64_alloc", aidx64, 0);
    check_val("rst64_num", num64, 64);
    check_val("rst64_empty", emp64, 1);
    check_val("rst64_err", err64, 0);
    check_val("rst64_nf", nf64, 1);
    check_val("rst48_num", num48, 48);
    check_val("rst48_nf", nf48, 1);

    // Drain all 64 entries back to back
    for (int i = 0; i < 64; i++) begin
      check_val("seq_alloc", aidx64, i);
      enq64 = 1'b1;
      tick();
    end
    enq64 = 1'b0;
    check_val("full_nf", nf64, 0);
    check_val("full_num", num64, 0);
    check_val("full_err", err64, 0);
    check_val("full_empty", emp64, 0);

    // Two releases in one cycle: port0 idx5, port1 idx9
    free64 = 2'b11;
    fidx64 = {6'd9, 6'd5};
    tick();
    free64 = 2'b00;
    check_val("rel_t1_num", num64, 0);
    tick();
    check_val("rel_t2_num", num64, 2);
    check_val("rel_t2_nf", nf64, 0);
    tick();
    check_val("rel_t3_nf", nf64, 1);
    check_val("rel_t3_alloc", aidx64, 5);
    enq64 = 1'b1;
    tick();
    enq64 = 1'b0;
    check_val("rel_next_alloc", aidx64, 9);
    check_val("rel_next_num", num64, 1);
    enq64 = 1'b1;
    tick();
    enq64 = 1'b0;
    check_val("refull_num", num64, 0);
    check_val("refull_nf", nf64, 0);
    check_val("refull_err", err64, 0);

    // Same index on both ports: both rejected
    free64 = 2'b11;
    fidx64 = {6'd7, 6'd7};
    tick();
    free64 = 2'b00;
    tick();
    check_val("dup_err", err64, 1);
    check_val("dup_num", num64, 0);
    tick();
    check_val("dup_nf", nf64, 0);
    check_val("dup_num2", num64, 0);

    // Async reset then free of a never-allocated entry
    rst64 = 1'b0;
    #1;
    check_val("arst64_err", err64, 0);
    check_val("arst64_num", num64, 64);
    check_val("arst64_alloc", aidx64, 0);
    @(posedge clk);
    #1;
    rst64 = 1'b1;
    tick();
    free64 = 2'b01;
    fidx64 = {6'd0, 6'd3};
    tick();
    free64 = 2'b00;
    tick();
    check_val("dbl_err", err64, 1);
    check_val("dbl_num", num64, 64);
    check_val("dbl_empty", emp64, 1);

    // 48 entries with MIN_FREE_SLOTS=4
    for (int i = 0; i < 45; i++) begin
      check_val("a48_alloc", aidx48, i);
      check_val("a48_nf", nf48, 1);
      enq48 = 1'b1;
      tick();
    end
    enq48 = 1'b0;
    check_val("a48_num", num48, 3);
    check_val("a48_nf_low", nf48, 0);
    check_val("a48_prefetch", aidx48, 45);
    free48 = 2'b01;
    fidx48 = {6'd0, 6'd10};
    tick();
    free48 = 2'b00;
    check_val("f48_t1_nf", nf48, 0);
    check_val("f48_t1_num", num48, 3);
    tick();
    check_val("f48_t2_nf", nf48, 1);
    check_val("f48_t2_num", num48, 4);
    check_val("f48_err", err48, 0);

    // Out-of-range index on a non-power-of-2 depth
    free48 = 2'b10;
    fidx48 = {6'd50, 6'd0};
    tick();
    free48 = 2'b00;
    tick();
    check_val("oor_err", err48, 1);
    check_val("oor_num", num48, 4);

    // Reset mid-stream with 10 allocated and a release staged
    rst48 = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst48 = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      enq48 = 1'b1;
      tick();
    end
    enq48 = 1'b0;
    check_val("mid_num", num48, 38);
    check_val("mid_alloc", aidx48, 10);
    free48 = 2'b01;
    fidx48 = {6'd0, 6'd3};
    tick();
    free48 = 2'b00;
    #2;
    rst48 = 1'b0;
    #1;
    check_val("mid_arst_alloc", aidx48, 0);
    check_val("mid_arst_num", num48, 48);
    check_val("mid_arst_empty", emp48, 1);
    @(posedge clk);
    #1;
    rst48 = 1'b1;
    tick();
    tick();
    check_val("post_alloc", aidx48, 0);
    check_val("post_num", num48, 48);
    check_val("post_empty", emp48, 1);
    check_val("post_err", err48, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
